periph_write_sequencer: RTL

- Bus initiator for the peripheral register bus; it drives the master side that the peripheral block responds to (enable, address, write data, write_enable).
- The CPU or loader pushes queued register-write entries into an internal FIFO, and the block replays them onto the peripheral bus, one access per entry.
- After each access it honours the peripheral's wait_video stall, so display-list style sequences (player, playfield and color updates interleaved with hblank/vblank waits) can run without CPU polling.

---
 rtl/periph_write_sequencer_if.sv | 28 ++
 rtl/periph_write_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/periph_write_sequencer_if.sv
// Peripheral register bus between the write sequencer (master) and the
// peripheral block (slave).
interface periph_write_sequencer_if;
    logic       bus_enable;
    logic [5:0] bus_address;
    logic [7:0] bus_data_out;
    logic       bus_write_enable;
    logic [7:0] bus_data_in;
    logic       wait_video;

    modport master (
        output bus_enable,
        output bus_address,
        output bus_data_out,
        output bus_write_enable,
        input  bus_data_in,
        input  wait_video
    );

    modport slave (
        input  bus_enable,
        input  bus_address,
        input  bus_data_out,
        input  bus_write_enable,
        output bus_data_in,
        output wait_video
    );
endinterface

// File: rtl/periph_write_sequencer.sv
// Replays queued register writes from a FIFO onto the peripheral bus, honouring
// the wait_video stall after each access. PERIPH_SEQ_READBACK_EN adds read entries.
module periph_write_sequencer #(
    parameter int DEPTH         = 16,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                     raw_clk,
    input  logic                     reset,
    input  logic                     push_valid,
    input  logic [14:0]              push_entry,
    output logic                     push_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    periph_write_sequencer_if.master bus,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ack
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SETTLE,
        ST_WAIT
    } state_t;

    logic [14:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [14:0]      head_entry;

    state_t           state_reg, state_next;
    logic [SET_W-1:0] settle_reg, settle_next;
    logic [5:0]       addr_reg, addr_next;
    logic [7:0]       data_reg, data_next;
    logic             is_read_reg, is_read_next;

    logic             bus_en_reg, bus_we_reg;
    logic [5:0]       bus_addr_reg;
    logic [7:0]       bus_dout_reg;

    logic             push_fire, pop, head_is_read, read_stall, capture;

    assign head_entry = fifo_mem[rd_ptr_reg];
    assign push_ready = (count_reg != CNT_W'(DEPTH));
    assign push_fire  = push_valid && push_ready;
    assign fifo_count = count_reg;
    assign busy       = (state_reg != ST_IDLE) || (count_reg != '0);

    // A flush also withholds the head so the discarded entries never reach the bus.
    assign pop = (state_reg == ST_IDLE) && (count_reg != '0) && !bus.wait_video
                 && !read_stall && !flush;

    assign capture = (state_reg == ST_SETTLE) && (settle_reg == '0) && is_read_reg;

    always_ff @(posedge raw_clk) begin
        if (push_fire && !flush) begin
            fifo_mem[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_fire) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)       rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_fire, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_comb begin
        state_next   = state_reg;
        settle_next  = settle_reg;
        addr_next    = addr_reg;
        data_next    = data_reg;
        is_read_next = is_read_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pop) begin
                    addr_next    = head_entry[13:8];
                    data_next    = head_entry[7:0];
                    is_read_next = head_is_read;
                    state_next   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                settle_next = '0;
                state_next  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_reg == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_next = ST_WAIT;
                end else begin
                    settle_next = settle_reg + 1'b1;
                end
            end
            ST_WAIT: begin
                if (!bus.wait_video) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they are live only during ISSUE.
    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            settle_reg   <= '0;
            addr_reg     <= '0;
            data_reg     <= '0;
            is_read_reg  <= 1'b0;
            bus_en_reg   <= 1'b0;
            bus_we_reg   <= 1'b0;
            bus_addr_reg <= '0;
            bus_dout_reg <= '0;
        end else begin
            state_reg    <= state_next;
            settle_reg   <= settle_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            is_read_reg  <= is_read_next;
            bus_en_reg   <= (state_next == ST_ISSUE);
            bus_we_reg   <= (state_next == ST_ISSUE) && !is_read_next;
            bus_addr_reg <= (state_next == ST_ISSUE) ? addr_next : 6'd0;
            bus_dout_reg <= (state_next == ST_ISSUE && !is_read_next) ? data_next : 8'd0;
        end
    end

    assign bus.bus_enable       = bus_en_reg;
    assign bus.bus_write_enable = bus_we_reg;
    assign bus.bus_address      = bus_addr_reg;
    assign bus.bus_data_out     = bus_dout_reg;

`ifdef PERIPH_SEQ_READBACK_EN
    logic [7:0] rd_data_reg;
    logic       rd_valid_reg;

    assign head_is_read = head_entry[14];
    assign read_stall   = head_is_read && rd_valid_reg;

    // A capture takes priority over an acknowledge in the same cycle.
    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else if (capture) begin
            rd_data_reg  <= bus.bus_data_in;
            rd_valid_reg <= 1'b1;
        end else if (rd_ack && rd_valid_reg) begin
            rd_valid_reg <= 1'b0;
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
`else
    logic unused_readback;

    assign head_is_read    = 1'b0;
    assign read_stall      = 1'b0;
    assign rd_data         = 8'd0;
    assign rd_valid        = 1'b0;
    assign unused_readback = ^{rd_ack, head_entry[14], bus.bus_data_in, capture};
`endif
endmodule
